mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the core's data bus, downstream of the core's we/address/data_out port.

---
 rtl/mmio_uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 158 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MMIO UART blocks: register offsets, STATUS bit positions and
// serialiser state encodings.
package mmio_uart_pkg;

  localparam logic [1:0] OffTxData = 2'd0;
  localparam logic [1:0] OffStatus = 2'd1;
  localparam logic [1:0] OffBaud   = 2'd2;
  localparam logic [1:0] OffRsvd   = 2'd3;

  localparam int unsigned StatActive = 0;
  localparam int unsigned StatFull   = 1;
  localparam int unsigned StatEmpty  = 2;
  localparam int unsigned StatOvf    = 3;
  localparam int unsigned StatParity = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read; a pop frees a slot for a push on the same
// edge, so push+pop on a full FIFO is accepted and the level is unchanged.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == FullLevel);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, sticky overflow and runtime baud divider.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic ParityEn = 1'b1;
`else
  localparam logic ParityEn = 1'b0;
`endif
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  offset;
  logic        wr_en, push, pop, full, empty, last;
  logic [LW-1:0] level;
  logic [7:0]  head, shreg_q, shreg_d;
  logic [15:0] baud_q, div_q, div_d, cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        ovf_q, par_q, par_d, tx_q, tx_d;
  logic [31:0] status;
  uart_state_e state_q, state_d;
  logic        unused_bits;

  assign sel         = (address[31:4] == BASE_ADDR[31:4]);
  assign offset      = address[3:2];
  assign wr_en       = we && sel;
  assign push        = wr_en && (offset == OffTxData);
  assign unused_bits = ^{wdata[31:16], address[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (wdata[7:0]),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_q <= 16'(CLKS_PER_BIT);
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en && offset == OffBaud) baud_q <= wdata[15:0];
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end else if (wr_en && offset == OffStatus && wdata[StatOvf]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    status             = '0;
    status[StatActive] = (state_q != StIdle);
    status[StatFull]   = full;
    status[StatEmpty]  = empty;
    status[StatOvf]    = ovf_q;
    status[StatParity] = ParityEn;
    status[15:8]       = 8'(level);
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (offset)
        OffTxData: rdata = '0;
        OffStatus: rdata = status;
        OffBaud:   rdata = {16'h0, baud_q};
        OffRsvd:   rdata = '0;
        default:   rdata = '0;
      endcase
    end
  end

  assign last = (cnt_q == div_q - 16'd1);
  // Pop in IDLE, or at the end of STOP so consecutive frames run without an idle gap.
  assign pop  = !empty && (state_q == StIdle || (state_q == StStop && last));
  assign busy = (state_q != StIdle) || !empty;
  assign tx   = tx_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      div_q   <= 16'd1;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!empty) state_d = StStart;
      StStart:  if (last) state_d = StData;
      StData:   if (last && bit_q == 3'd7) state_d = ParityEn ? StParity : StStop;
      StParity: if (last) state_d = StStop;
      StStop:   if (last) state_d = empty ? StIdle : StStart;
      default:  state_d = StIdle;
    endcase
  end

  // tx is decoded from the next state so the line changes on the same edge as the state.
  always_comb begin
    cnt_d   = (state_q == StIdle || last) ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    div_d   = div_q;
    if (pop) begin
      shreg_d = head;
      par_d   = ^head;
      div_d   = (baud_q == 16'd0) ? 16'd1 : baud_q;
    end else if (state_q == StData && last) begin
      shreg_d = {1'b1, shreg_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: stimulus queues expected frames, a serial monitor decodes tx and
// checks each frame (bits, bit widths, back-to-back chaining) against the queue.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int unsigned NB   = 11;
  localparam logic [31:0] PBIT = 32'h10;
`else
  localparam int unsigned NB   = 10;
  localparam logic [31:0] PBIT = 32'h0;
`endif

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         chained;
  } frame_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        we = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic        sel, tx, busy;
  logic [31:0] rdata;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .we      (we),
    .address (address),
    .wdata   (wdata),
    .sel     (sel),
    .rdata   (rdata),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int div, input bit ch);
    frame_t f;
    f.data    = d;
    f.div     = div;
    f.chained = ch;
    exp_q.push_back(f);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we      = 1'b1;
    address = a;
    wdata   = d;
  endtask

  task automatic release_bus();
    @(negedge clk);
    we      = 1'b0;
    address = '0;
    wdata   = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    put(a, d);
    release_bus();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clk);
    we      = 1'b0;
    address = a;
    #1;
    d = rdata;
    s = sel;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  // Serial monitor: samples tx on every falling clock edge.
  initial begin : monitor
    frame_t     e;
    logic [10:0] bits;
    bit         ok_w, aborted, skip;
    int         w;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (resetn === 1'b1 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: start bit seen with no frame queued");
          w = 0;
          while (tx !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
          end
        end else begin
          e       = exp_q.pop_front();
          bits    = '1;
          ok_w    = 1'b1;
          aborted = 1'b0;
          for (int k = 0; k < NB * e.div && !aborted; k++) begin
            if (k != 0) @(negedge clk);
            if (resetn !== 1'b1) aborted = 1'b1;
            else if (k % e.div == 0) bits[k / e.div] = tx;
            else if (tx !== bits[k / e.div]) ok_w = 1'b0;
          end
          if (!aborted) begin
            check("start_bit", {31'h0, bits[0]}, 32'h0);
            check("data", {24'h0, bits[8:1]}, {24'h0, e.data});
`ifdef MMIO_UART_TX_PARITY_EN
            check("parity", {31'h0, bits[9]}, {31'h0, ^e.data});
            check("stop_bit", {31'h0, bits[10]}, 32'h1);
`else
            check("stop_bit", {31'h0, bits[9]}, 32'h1);
`endif
            check("bit_width", {31'h0, ok_w}, 32'h1);
            if (e.chained) begin
              @(negedge clk);
              check("no_gap", {31'h0, tx}, 32'h0);
              skip = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] d;
    logic        s;
    int          n;

    // Reset state
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rd(BASE + 32'h4, d, s);
    check("rst_status", d, 32'h4 | PBIT);
    check("rst_sel", {31'h0, s}, 32'h1);
    rd(BASE + 32'h8, d, s);
    check("rst_baud", d, 32'h4);
    rd(BASE, d, s);
    check("txdata_reads_0", d, 32'h0);
    rd(BASE + 32'hC, d, s);
    check("rsvd_reads_0", d, 32'h0);

    // 0x55 at div 4: start one cycle after the push edge, busy high for NB*4+1 samples
    expect_frame(8'h55, 4, 1'b0);
    store(BASE, 32'h55);
    check("tx_high_after_push", {31'h0, tx}, 32'h1);
    @(negedge clk);
    check("start_latency", {31'h0, tx}, 32'h0);
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_cycles", n, NB * 4 + 1);
    repeat (3) @(negedge clk);

    // Divider 3
    store(BASE + 32'h8, 32'hFFFF_0003);
    rd(BASE + 32'h8, d, s);
    check("baud_3", d, 32'h3);
    expect_frame(8'hA5, 3, 1'b0);
    store(BASE, 32'hA5);
    wait_idle(200, "idle_div3");

    // Divider 0 behaves as 1
    store(BASE + 32'h8, 32'h0);
    rd(BASE + 32'h8, d, s);
    check("baud_0", d, 32'h0);
    expect_frame(8'h3C, 1, 1'b0);
    store(BASE, 32'h3C);
    wait_idle(200, "idle_div0");

    // Nine stores into an empty FIFO behind an active frame: ninth dropped, overflow set
    store(BASE + 32'h8, 32'h4);
    expect_frame(8'hF0, 4, 1'b1);
    store(BASE, 32'hF0);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) expect_frame(8'(i * 8'h11), 4, i < 8);
      put(BASE, 32'(i * 8'h11));
    end
    release_bus();
    rd(BASE + 32'h4, d, s);
    check("status_overflow", d, 32'h080B | PBIT);
    store(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, d, s);
    check("status_ovf_cleared", d, 32'h0803 | PBIT);
    wait_idle(1000, "idle_burst");

    // Three queued behind an active frame; out-of-window read
    expect_frame(8'h01, 4, 1'b1);
    store(BASE, 32'h01);
    repeat (2) @(negedge clk);
    expect_frame(8'h02, 4, 1'b1);
    expect_frame(8'h03, 4, 1'b1);
    expect_frame(8'h04, 4, 1'b0);
    put(BASE, 32'h02);
    put(BASE, 32'h03);
    put(BASE, 32'h04);
    release_bus();
    rd(BASE + 32'h4, d, s);
    check("status_level3", d, 32'h0301 | PBIT);
    rd(32'h0000_3000, d, s);
    check("far_sel", {31'h0, s}, 32'h0);
    check("far_rdata", d, 32'h0);
    wait_idle(600, "idle_level3");

    // Asynchronous reset mid-frame: tx high immediately, FIFO and registers reset
    store(BASE + 32'h8, 32'h7);
    expect_frame(8'h5A, 7, 1'b0);
    put(BASE, 32'h5A);
    put(BASE, 32'h6B);
    release_bus();
    repeat (2) @(negedge clk);
    check("tx_low_before_reset", {31'h0, tx}, 32'h0);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_tx", {31'h0, tx}, 32'h1);
    check("async_reset_busy", {31'h0, busy}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rd(BASE + 32'h4, d, s);
    check("post_rst_status", d, 32'h4 | PBIT);
    rd(BASE + 32'h8, d, s);
    check("post_rst_baud", d, 32'h4);
    expect_frame(8'hC3, 4, 1'b0);
    store(BASE, 32'hC3);
    wait_idle(200, "idle_after_reset");

    check("queue_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
